// File: rtl/ibex_obi_arb_pkg.sv
// Shared types and limits for the OBI arbiter slice.
// Request/response structs are fixed at 32-bit so other blocks can use them without parameters.
package ibex_obi_arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_OUTST   = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;

    // Index width that stays at least one bit for single-entry cases.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ibex_obi_arb_id_fifo.sv
// In-order FIFO of granted master indices; the head selects which master receives the next response.
module ibex_obi_arb_id_fifo
    import ibex_obi_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = idx_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) rptr_q <= ptr_inc(rptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ibex_obi_arbiter.sv
// Round-robin N:1 OBI arbiter with an in-order ID FIFO for response routing.
// Selection is locked while a request waits for grant so the downstream payload stays stable.
module ibex_obi_arbiter
    import ibex_obi_arb_pkg::*;
#(
    parameter  int NUM_MASTERS     = 2,
    parameter  int MAX_OUTSTANDING = 2,
    parameter  int ADDR_W          = 32,
    parameter  int DATA_W          = 32,
    localparam int BE_W            = DATA_W/8,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING+1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_MASTERS-1:0]        m_req_i,
    output logic [NUM_MASTERS-1:0]        m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS*BE_W-1:0]   m_be_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]        m_rvalid_o,
    output logic [DATA_W-1:0]             m_rdata_o,
    output logic                          m_err_o,
    output logic                          s_req_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic                          s_we_o,
    output logic [BE_W-1:0]               s_be_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    input  logic                          s_gnt_i,
    input  logic                          s_rvalid_i,
    input  logic                          s_err_i,
    input  logic [DATA_W-1:0]             s_rdata_i,
    output logic [CNT_W-1:0]              outstanding_o,
    output logic                          protocol_err_o
);

    localparam int IDX_W = idx_width(NUM_MASTERS);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] arb_idx, sel_idx, head_idx, idx_lo, idx_hi;
    logic             lock_q, lock_d, rst_done_q, perr_q, perr_d;
    logic             found_hi, fifo_full, fifo_empty, push, pop;

    // Requesters at or above rr_ptr win first; otherwise wrap to the lowest requester.
    always_comb begin
        idx_lo   = '0;
        idx_hi   = '0;
        found_hi = 1'b0;
        for (int k = NUM_MASTERS-1; k >= 0; k--) begin
            if (m_req_i[k]) idx_lo = IDX_W'(k);
            if (m_req_i[k] && (k >= int'(rr_ptr_q))) begin
                idx_hi   = IDX_W'(k);
                found_hi = 1'b1;
            end
        end
        arb_idx = found_hi ? idx_hi : idx_lo;
    end

    assign sel_idx = lock_q ? lock_idx_q : arb_idx;
    assign s_req_o = (|m_req_i) & ~fifo_full & rst_done_q;
    assign push    = s_req_o & s_gnt_i;
    assign pop     = s_rvalid_i & ~fifo_empty;

    always_comb begin
        s_addr_o   = '0;
        s_we_o     = 1'b0;
        s_be_o     = '0;
        s_wdata_o  = '0;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (sel_idx == IDX_W'(k)) begin
                s_addr_o   = m_addr_i[k*ADDR_W +: ADDR_W];
                s_we_o     = m_we_i[k];
                s_be_o     = m_be_i[k*BE_W +: BE_W];
                s_wdata_o  = m_wdata_i[k*DATA_W +: DATA_W];
                m_gnt_o[k] = push;
            end
            if (head_idx == IDX_W'(k)) m_rvalid_o[k] = pop;
        end
    end

    assign m_rdata_o      = s_rdata_i;
    assign m_err_o        = s_err_i;
    assign protocol_err_o = perr_q;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = 1'b0;
        lock_idx_d = lock_idx_q;
        perr_d     = perr_q | (s_rvalid_i & fifo_empty);
        if (push) begin
            rr_ptr_d = (sel_idx == IDX_W'(NUM_MASTERS-1)) ? '0 : sel_idx + IDX_W'(1);
        end else if (s_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
        end
    end

    // rst_done_q keeps the downstream request quiet for the first cycle after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            perr_q     <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            perr_q     <= perr_d;
            rst_done_q <= 1'b1;
        end
    end

    ibex_obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (sel_idx),
        .pop_i   (pop),
        .rdata_o (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

endmodule
